// File: rtl/gobang_win_checker.sv
// gobang_win_checker: scans a snapshotted 15x15 board one cell per clock and reports the first five-in-a-row or a conflict
// Ports: clk, reset (sync, active-high), start (sampled in IDLE), humanIn/aiIn (boards, bit i = cell i),
//        busy (state != IDLE), done (one-cycle pulse), winner (00 none, 01 human, 10 AI, 11 conflict),
//        winX/winY (row/col of the line's lowest-index cell), winDir (0 horiz, 1 vert, 2 diag, 3 anti-diag)
module gobang_win_checker #(
   parameter int BOARD = 15,
   parameter int WIN_LEN = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [BOARD*BOARD-1:0]   humanIn,
   input  logic [BOARD*BOARD-1:0]   aiIn,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               winner,
   output logic [3:0]               winX,
   output logic [3:0]               winY,
   output logic [1:0]               winDir
);
   localparam int N = BOARD * BOARD;
   localparam int AW = $clog2(N);
   localparam int STEP [4] = '{1, BOARD, BOARD + 1, BOARD - 1};
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, state_next;
   logic [N-1:0] snap_h, snap_a;
   logic [3:0] row, col;
   logic [3:0] fit, hh, ha;
   logic conflict, hit, last;
   logic [1:0] res_w, res_d;
   int idx;

   // out-of-board positions only occur when the fit guard already rejects the line
   function automatic logic line_at(input logic [N-1:0] b, input int base, input int step);
      logic ok;
      int p;
      ok = 1'b1;
      for (int k = 0; k < WIN_LEN; k++) begin
         p = base + k * step;
         ok = ok & (p < N) & (p < N ? b[p[AW-1:0]] : 1'b0);
      end
      return ok;
   endfunction

   function automatic logic [1:0] first(input logic [3:0] m);
      return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
   endfunction

   always_comb begin
      idx = int'(row) * BOARD + int'(col);
      fit[0] = int'(col) <= BOARD - WIN_LEN;
      fit[1] = int'(row) <= BOARD - WIN_LEN;
      fit[2] = fit[0] & fit[1];
      fit[3] = fit[1] & (int'(col) >= WIN_LEN - 1);
      for (int d = 0; d < 4; d++) begin
         hh[d] = fit[d] & line_at(snap_h, idx, STEP[d]);
         ha[d] = fit[d] & line_at(snap_a, idx, STEP[d]);
      end
      conflict = snap_h[idx[AW-1:0]] & snap_a[idx[AW-1:0]];
      hit = conflict | (|hh) | (|ha);
      last = (int'(row) == BOARD - 1) & (int'(col) == BOARD - 1);
      res_w = conflict ? 2'd3 : |hh ? 2'd1 : |ha ? 2'd2 : 2'd0;
      res_d = conflict ? 2'd0 : first(|hh ? hh : ha);
      state_next = (state == IDLE) ? (start ? SCAN : IDLE) :
                   (state == SCAN) ? ((hit | last) ? DONE : SCAN) : IDLE;
      busy = state != IDLE;
      done = state == DONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         snap_h <= '0;
         snap_a <= '0;
         row <= '0;
         col <= '0;
         winner <= '0;
         winX <= '0;
         winY <= '0;
         winDir <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            snap_h <= humanIn;
            snap_a <= aiIn;
            row <= '0;
            col <= '0;
         end
         if (state == SCAN) begin
            if (hit | last) begin
               winner <= hit ? res_w : 2'd0;
               winX <= hit ? row : 4'd0;
               winY <= hit ? col : 4'd0;
               winDir <= hit ? res_d : 2'd0;
            end else if (int'(col) == BOARD - 1) begin
               col <= '0;
               row <= row + 4'd1;
            end else begin
               col <= col + 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_gobang_win_checker.sv
// tb_gobang_win_checker: directed and randomized checks of gobang_win_checker against a row/column board model
module tb_gobang_win_checker;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [224:0] humanIn = '0, aiIn = '0;
   logic busy, done;
   logic [1:0] winner, winDir;
   logic [3:0] winX, winY;
   int passed = 0, total = 0;
   bit hb [15][15];
   bit ab [15][15];
   localparam int DR [4] = '{0, 1, 1, 1};
   localparam int DC [4] = '{1, 0, 1, -1};

   gobang_win_checker dut (
      .clk(clk), .reset(reset), .start(start), .humanIn(humanIn), .aiIn(aiIn),
      .busy(busy), .done(done), .winner(winner), .winX(winX), .winY(winY), .winDir(winDir)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clear_board();
      foreach (hb[r, c]) begin
         hb[r][c] = 1'b0;
         ab[r][c] = 1'b0;
      end
   endtask

   // p: 1 human, 2 AI, 3 both (conflict)
   task automatic put(input int p, input int r, input int c);
      hb[r][c] = (p != 2);
      ab[r][c] = (p != 1);
   endtask

   task automatic plant(input int p, input int r, input int c, input int d);
      for (int k = 0; k < 5; k++) put(p, r + k * DR[d], c + k * DC[d]);
   endtask

   function automatic bit five(input int p, input int r, input int c, input int d);
      for (int k = 0; k < 5; k++) begin
         int rr, cc;
         rr = r + k * DR[d];
         cc = c + k * DC[d];
         if (rr < 0 || rr > 14 || cc < 0 || cc > 14) return 1'b0;
         if (p == 1 ? !hb[rr][cc] : !ab[rr][cc]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model(output int w, output int x, output int y, output int dir, output int cyc);
      w = 0; x = 0; y = 0; dir = 0; cyc = 226;
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 15; c++)
            if (w == 0) begin
               if (hb[r][c] && ab[r][c]) begin
                  w = 3; x = r; y = c; dir = 0;
               end else begin
                  for (int p = 1; p <= 2; p++)
                     for (int d = 0; d < 4; d++)
                        if (w == 0 && five(p, r, c, d)) begin
                           w = p; x = r; y = c; dir = d;
                        end
               end
               if (w != 0) cyc = r * 15 + c + 2;
            end
   endtask

   task automatic load();
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 15; c++) begin
            humanIn[8'(r * 15 + c)] = hb[r][c];
            aiIn[8'(r * 15 + c)] = ab[r][c];
         end
   endtask

   task automatic run(input string tag, input bit glitch);
      int w, x, y, dir, ecyc, cyc;
      bit got, busy_ok;
      model(w, x, y, dir, ecyc);
      @(negedge clk);
      load();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (glitch) begin
         humanIn = ~humanIn;
         aiIn = ~aiIn;
      end
      cyc = 1; got = 1'b0; busy_ok = 1'b1;
      while (!got && cyc < 300) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) got = 1'b1;
         else begin
            start = glitch && cyc == 40;
            cyc++;
         end
      end
      start = 1'b0;
      chk({tag, "_cycle"}, cyc, ecyc);
      chk({tag, "_winner"}, 32'(winner), w);
      chk({tag, "_winX"}, 32'(winX), x);
      chk({tag, "_winY"}, 32'(winY), y);
      chk({tag, "_winDir"}, 32'(winDir), dir);
      chk({tag, "_busy"}, 32'(busy_ok), 1);
      @(negedge clk);
      chk({tag, "_idle"}, {30'd0, busy, done}, 0);
   endtask

   initial begin
      int cyc;
      bit seen;
      clear_board();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_winner", 32'(winner), 0);
      chk("rst_winX", 32'(winX), 0);
      chk("rst_winY", 32'(winY), 0);
      chk("rst_winDir", 32'(winDir), 0);
      reset = 1'b0;
      clear_board();
      run("empty", 1'b0);
      clear_board(); plant(1, 7, 3, 0);
      run("human_row", 1'b0);
      clear_board(); plant(2, 0, 14, 3);
      run("ai_anti", 1'b0);
      clear_board();
      for (int i = 12; i <= 16; i++) put(1, i / 15, i % 15);
      run("wrap", 1'b0);
      clear_board(); put(3, 3, 5); plant(1, 6, 10, 0);
      run("conflict", 1'b0);
      clear_board();
      @(negedge clk);
      load();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1; seen = 1'b0;
      while (cyc < 60) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
         cyc++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_winner", 32'(winner), 0);
      chk("midrst_winX", 32'(winX), 0);
      chk("midrst_winY", 32'(winY), 0);
      chk("midrst_winDir", 32'(winDir), 0);
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("midrst_nodone", 32'(seen), 0);
      clear_board(); plant(2, 9, 2, 2);
      run("after_reset", 1'b0);
      clear_board(); plant(1, 7, 3, 0);
      run("glitch", 1'b1);
      for (int n = 0; n < 20; n++) begin
         clear_board();
         foreach (hb[r, c]) begin
            int v;
            v = int'($urandom_range(0, 9));
            if (v < 2) put(1, r, c);
            else if (v < 3) put(2, r, c);
         end
         if ($urandom_range(0, 1) == 1) begin
            int d, r, c;
            d = int'($urandom_range(0, 3));
            r = d == 0 ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 10));
            c = d == 1 ? int'($urandom_range(0, 14)) : d == 3 ? int'($urandom_range(4, 14)) : int'($urandom_range(0, 10));
            plant(int'($urandom_range(1, 2)), r, c, d);
         end
         if (n % 5 == 0) put(3, int'($urandom_range(0, 14)), int'($urandom_range(0, 14)));
         run($sformatf("rand%0d", n), 1'b0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/gobang_win_checker.md
# gobang_win_checker

Sequential five-in-a-row detector sitting directly downstream of the AI move generator. On each `start` it snapshots the human and AI 225-bit board vectors (AI vector = the move generator's `AIOut`). It then scans the 15×15 board one cell per clock and reports the first winning line found, or "no winner". The game controller runs it after every placed stone to decide whether to end the game.

## Interface
Parameters
- `BOARD`, 15: board edge length; cell index = row*BOARD + col (row = x, col = y).
- `WIN_LEN`, 5: stones in a line required to win.

Ports
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a check; sampled only in IDLE.
- `humanIn`  in  225  human stones; bit i = cell i.
- `aiIn`  in  225  AI stones; bit i = cell i.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; results valid from this cycle on.
- `winner`  out  2  00 none, 01 human, 10 AI, 11 board conflict.
- `winX`  out  4  row of the reported cell.
- `winY`  out  4  column of the reported cell.
- `winDir`  out  2  line direction: 0 horizontal (+1), 1 vertical (+15), 2 diagonal (+16), 3 anti-diagonal (+14).

## Operation
- States: IDLE, SCAN, DONE.
- IDLE → SCAN when `start`=1.
  - Copy both boards into internal snapshot registers.
  - Clear row/col counters to 0.
  - Later input changes do not affect the scan.
- SCAN evaluates the current cell (row, col) against the snapshot, in this priority order:
  1. Conflict: both bits set. Result winner=11, winX/winY=cell, winDir=0.
  2. Human five starting at this cell. Directions are checked in order 0, 1, 2, 3, and the first match is reported.
  3. AI five starting at this cell, same direction order.
- A line must fit on the board without wrap:
  - dir 0 needs col ≤ 10.
  - dir 1 needs row ≤ 10.
  - dir 2 needs row ≤ 10 and col ≤ 10.
  - dir 3 needs row ≤ 10 and col ≥ 4.
- Every cell of the line must hold the same player's stone.
- The reported cell is always the lowest-index stone of the line. Runs of six or more count as a win and are reported at the first cell whose five-run is complete.
- Hit: register the result and go to DONE.
- No hit at (14,14): register winner=00, winX=winY=winDir=0, and go to DONE.
- Otherwise advance col; at col=14, wrap to col 0 and row+1. Counters run row/col directly, with no divider.
- DONE: `done`=1 for one cycle, then IDLE.
- `winner`, `winX`, `winY` and `winDir` hold until the next scan's DONE.
- `start` while busy is ignored, with no queuing.
- `start` held high in the DONE cycle's successor (IDLE) begins a new scan.

## Timing
- Reset values: `busy`=0, `done`=0, `winner`=00, `winX`=0, `winY`=0, `winDir`=0, state IDLE.
- Reset asserted in any state, including mid-SCAN, returns to IDLE with all outputs at reset values on the next edge. No `done` pulse is produced.
- Cycle numbering: `start` is sampled high in cycle 0.
  - Cell k (k = row*15+col) is evaluated in cycle k+1.
  - A hit at cell k gives `done` high in cycle k+2.
  - No winner gives `done` in cycle 226.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Result outputs update on the same edge that raises `done`.
- Worst-case latency is 226 cycles; back-to-back checks are possible every 227 cycles.

## Test plan
- Empty boards, `start` pulse → `done` in cycle 226, winner=00, busy high for cycles 1–226.
- Human at (7,3)…(7,7), i.e. idx 108–112 → `done` in cycle 110, winner=01, winX=7, winY=3, winDir=0.
- AI anti-diagonal (0,14),(1,13),(2,12),(3,11),(4,10) → `done` in cycle 16, winner=10, winX=0, winY=14, winDir=3.
- Wrap-around: human idx 12–16, i.e. (0,12..14) and (1,0..1) → winner=00 in cycle 226.
- Conflict: both bits set at idx 50, plus a human five at idx 100–104 → winner=11, winX=3, winY=5 in cycle 52.
- Robustness:
  - Pulse `start` again at cycle 40 → ignored.
  - Change inputs after cycle 0 → result follows the snapshot.
  - Assert `reset` at cycle 60 → outputs zero, no `done`.
  - A new `start` then runs normally.
